// File: rtl/vga_fb_scheduler.sv
// Double-buffered 1-bpp frame-buffer scheduler.
// One single-port RAM is shared by two users. The display reader fetches one
// word two pixel clocks ahead of the beam and has fixed priority. The frame
// writer gets every other cycle, and always writes the bank that is not being
// shown. The banks swap only at the start of vertical blanking, so a frame is
// shown only after the writer has finished it.
module vga_fb_scheduler #(
  parameter int H_ACTIVE = 640,
  parameter int H_TOTAL  = 800,
  parameter int V_ACTIVE = 480,
  parameter int V_TOTAL  = 525,
  parameter int WORD_W   = 16
) (
  input  logic              pixel_clk,
  input  logic              rst_n,
  input  logic [9:0]        h_cnt,
  input  logic [9:0]        v_cnt,
  input  logic              wr_valid,
  input  logic [WORD_W-1:0] wr_data,
  output logic              wr_ready,
  output logic [15:0]       mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic [WORD_W-1:0] mem_wdata,
  input  logic [WORD_W-1:0] mem_rdata,
  output logic              pixel,
  output logic              pixel_valid,
  output logic              disp_bank,
  output logic              swap_pulse,
  output logic              frame_repeat
);

  localparam int WORDS_PER_LINE = H_ACTIVE / WORD_W;
  localparam int FRAME_WORDS    = WORDS_PER_LINE * V_ACTIVE;
  localparam int SH             = $clog2(WORD_W);

  // Fetch target: the pixel two clocks ahead of the beam. The target wraps
  // into the next line (and the next frame) during the last two clocks of a line.
  logic [10:0] w_h_p2;
  logic        w_h_wrap;
  logic [9:0]  w_x_t;
  logic [9:0]  w_y_t;
  logic        w_read_slot;
  logic [14:0] w_line_base;
  logic [14:0] w_rd_idx;
  logic        w_accept;
  logic        w_swap_pt;

  assign w_h_p2   = {1'b0, h_cnt} + 11'd2;
  assign w_h_wrap = (w_h_p2 >= 11'(H_TOTAL));
  assign w_x_t    = w_h_wrap ? 10'(w_h_p2 - 11'(H_TOTAL)) : w_h_p2[9:0];
  assign w_y_t    = !w_h_wrap ? v_cnt :
                    ((v_cnt == 10'(V_TOTAL - 1)) ? 10'd0 : v_cnt + 10'd1);

  // A word is fetched whenever the target is the first pixel of a visible word.
  assign w_read_slot = (w_x_t[SH-1:0] == '0) &&
                       (w_x_t < 10'(H_ACTIVE)) &&
                       (w_y_t < 10'(V_ACTIVE));

  // The word index is the exact line base plus the word within the line.
  // It stays below 2^15 for every visible target.
  assign w_line_base = 15'(w_y_t) * 15'(WORDS_PER_LINE);
  assign w_rd_idx    = w_line_base + 15'(w_x_t >> SH);

  logic              r_disp_bank;
  logic              r_frame_ready;
  logic [14:0]       r_wr_ptr;
  logic              r_rd_pend;
  logic [WORD_W-1:0] r_shift;
  logic              r_swap_pulse;
  logic              r_frame_repeat;

  // The writer is stalled by read slots and by a finished frame waiting to swap.
  assign wr_ready  = ~w_read_slot & ~r_frame_ready;
  assign w_accept  = wr_valid & wr_ready;
  assign w_swap_pt = (h_cnt == 10'd0) && (v_cnt == 10'(V_ACTIVE));

  assign mem_re    = w_read_slot;
  assign mem_we    = w_accept;
  assign mem_wdata = wr_data;
  assign mem_addr  = w_read_slot ? {r_disp_bank, w_rd_idx} : {~r_disp_bank, r_wr_ptr};

  assign pixel_valid  = (h_cnt < 10'(H_ACTIVE)) && (v_cnt < 10'(V_ACTIVE));
  assign pixel        = pixel_valid & r_shift[WORD_W-1];
  assign disp_bank    = r_disp_bank;
  assign swap_pulse   = r_swap_pulse;
  assign frame_repeat = r_frame_repeat;

  // Read return path. RAM data arrives the cycle after a slot and is loaded at
  // that clock edge, so its MSB is shown in the cycle where h_cnt equals the
  // target. In every other cycle the register shifts left by one pixel.
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_pend <= 1'b0;
      r_shift   <= '0;
    end else begin
      r_rd_pend <= w_read_slot;
      if (r_rd_pend) r_shift <= mem_rdata;
      else           r_shift <= {r_shift[WORD_W-2:0], 1'b0};
    end
  end

  // Write pointer, frame completion and bank swap at the start of vertical blanking.
  // When a frame is ready, wr_ready is low, so no word is accepted in a swap cycle.
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_disp_bank    <= 1'b0;
      r_frame_ready  <= 1'b0;
      r_wr_ptr       <= '0;
      r_swap_pulse   <= 1'b0;
      r_frame_repeat <= 1'b0;
    end else begin
      r_swap_pulse   <= 1'b0;
      r_frame_repeat <= 1'b0;
      if (w_accept) begin
        if (r_wr_ptr == 15'(FRAME_WORDS - 1)) begin
          r_wr_ptr      <= '0;
          r_frame_ready <= 1'b1;
        end else begin
          r_wr_ptr <= r_wr_ptr + 15'd1;
        end
      end
      if (w_swap_pt) begin
        if (r_frame_ready) begin
          r_disp_bank   <= ~r_disp_bank;
          r_frame_ready <= 1'b0;
          r_swap_pulse  <= 1'b1;
        end else begin
          r_frame_repeat <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_vga_fb_scheduler.sv
// Directed bench for vga_fb_scheduler: reset state, read slot addressing,
// the pixel path, arbitration across one line, full-frame swap and underrun.
module tb_vga_fb_scheduler;
  logic        pixel_clk = 1'b0;
  logic        rst_n     = 1'b0;
  logic [9:0]  h_cnt     = '0;
  logic [9:0]  v_cnt     = '0;
  logic        wr_valid  = 1'b0;
  logic [15:0] wr_data   = '0;
  logic        wr_ready;
  logic [15:0] mem_addr;
  logic        mem_re;
  logic        mem_we;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata = '0;
  logic        pixel;
  logic        pixel_valid;
  logic        disp_bank;
  logic        swap_pulse;
  logic        frame_repeat;

  logic [15:0] rd_word0 = '0;
  int          n_chk    = 0;
  int          n_pass   = 0;

  always #5 pixel_clk = ~pixel_clk;

  vga_fb_scheduler dut (
    .pixel_clk(pixel_clk), .rst_n(rst_n), .h_cnt(h_cnt), .v_cnt(v_cnt),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
    .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .pixel(pixel),
    .pixel_valid(pixel_valid), .disp_bank(disp_bank),
    .swap_pulse(swap_pulse), .frame_repeat(frame_repeat)
  );

  // RAM read model: word 0 returns rd_word0 and every other word returns 0.
  // The data is valid one cycle after mem_re.
  always @(posedge pixel_clk)
    if (mem_re) mem_rdata <= (mem_addr == 16'h0000) ? rd_word0 : 16'h0000;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, got, exp);
  endtask

  task automatic nxt();
    @(posedge pixel_clk); #1;
  endtask

  task automatic adv();
    if (h_cnt == 10'd799) begin
      h_cnt = 10'd0;
      v_cnt = (v_cnt == 10'd524) ? 10'd0 : v_cnt + 10'd1;
    end else h_cnt = h_cnt + 10'd1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; wr_valid = 1'b0;
    nxt(); nxt();
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int x, y, wcnt, n, bad;
    logic slot;
    logic [15:0] last;
    int dh [6] = '{798, 14, 622, 798, 638, 798};
    int dv [6] = '{524, 0, 0, 0, 0, 479};
    int dr [6] = '{1, 1, 1, 1, 0, 0};
    int da [6] = '{0, 1, 39, 40, 0, 0};

    // Reset state with random writer inputs.
    h_cnt = 10'd5; v_cnt = 10'd100;
    wr_valid = 1'($urandom); wr_data = 16'($urandom);
    nxt(); nxt();
    @(negedge pixel_clk);
    chk("rst_disp_bank", disp_bank, 0);
    chk("rst_swap_pulse", swap_pulse, 0);
    chk("rst_frame_repeat", frame_repeat, 0);
    chk("rst_wr_ready", wr_ready, 1);
    nxt();
    rst_n = 1'b1; wr_valid = 1'b1; wr_data = 16'hA5A5;
    @(negedge pixel_clk);
    chk("first_wr_addr", mem_addr, 16'h8000);
    chk("first_wr_we", mem_we, 1);
    chk("first_wr_data", mem_wdata, 16'hA5A5);
    nxt();

    // Directed read slots.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      h_cnt = 10'(dh[i]); v_cnt = 10'(dv[i]);
      @(negedge pixel_clk);
      chk($sformatf("slot_re_%0d", i), mem_re, 32'(dr[i]));
      if (dr[i] == 1) chk($sformatf("slot_addr_%0d", i), mem_addr, 32'(da[i]));
      nxt();
    end

    // Arbitration over one full line with the writer always valid.
    do_reset();
    wr_valid = 1'b1; wcnt = 0;
    for (int h = 0; h < 800; h++) begin
      h_cnt = 10'(h); v_cnt = 10'd0; wr_data = 16'(h);
      @(negedge pixel_clk);
      x = (h + 2) % 800;
      y = (h < 798) ? 0 : 1;
      slot = ((x % 16) == 0) && (x < 640);
      chk("excl", 32'(mem_re & mem_we), 0);
      chk("arb_re", mem_re, 32'(slot));
      chk("arb_rdy", wr_ready, 32'(!slot));
      if (slot) chk("arb_rd_addr", mem_addr, 32'(y * 40 + x / 16));
      else begin
        chk("arb_wr_addr", mem_addr, 32'h8000 + 32'(wcnt));
        wcnt++;
      end
      nxt();
    end
    wr_valid = 1'b0;
    chk("arb_wr_count", 32'(wcnt), 760);

    // Pixel path: word 0 = 8001 across the start of line 0.
    do_reset();
    rd_word0 = 16'h8001;
    h_cnt = 10'd796; v_cnt = 10'd524;
    for (int c = 0; c < 700; c++) begin
      @(negedge pixel_clk);
      if (v_cnt == 10'd0 && h_cnt <= 10'd15)
        chk($sformatf("pix_h%0d", h_cnt), pixel, 32'(h_cnt == 10'd0 || h_cnt == 10'd15));
      if (v_cnt == 10'd0 && h_cnt == 10'd640) begin
        chk("pix_h640", pixel, 0);
        chk("pixv_h640", pixel_valid, 0);
      end
      nxt(); adv();
    end

    // Pixel is gated outside the active area even with a 1 in the register MSB.
    do_reset();
    rd_word0 = 16'hFFFF;
    h_cnt = 10'd798; v_cnt = 10'd524; nxt();
    h_cnt = 10'd799; nxt();
    h_cnt = 10'd0; v_cnt = 10'd0;
    @(negedge pixel_clk);
    chk("gate_h0", pixel, 1);
    nxt();
    h_cnt = 10'd640;
    @(negedge pixel_clk);
    chk("gate_h640", pixel, 0);
    nxt();

    // Underrun: 100 words, then a swap point.
    do_reset();
    h_cnt = 10'd5; v_cnt = 10'd500; wr_valid = 1'b1;
    for (int c = 0; c < 100; c++) nxt();
    wr_valid = 1'b0;
    h_cnt = 10'd0; v_cnt = 10'd480;
    @(negedge pixel_clk);
    chk("ur_repeat_pre", frame_repeat, 0);
    nxt();
    h_cnt = 10'd1; wr_valid = 1'b1;
    @(negedge pixel_clk);
    chk("ur_repeat", frame_repeat, 1);
    chk("ur_bank", disp_bank, 0);
    chk("ur_swap", swap_pulse, 0);
    chk("ur_addr", mem_addr, 16'h8064);
    nxt();
    h_cnt = 10'd2;
    @(negedge pixel_clk);
    chk("ur_repeat_end", frame_repeat, 0);
    chk("ur_addr2", mem_addr, 16'h8065);
    wr_valid = 1'b0;
    nxt();

    // Full frame, then a swap.
    do_reset();
    h_cnt = 10'd5; v_cnt = 10'd500; wr_valid = 1'b1;
    n = 0; bad = 0; last = '0;
    for (int c = 0; c < 20000; c++) begin
      wr_data = 16'(c);
      @(negedge pixel_clk);
      if (!wr_ready) break;
      if (mem_addr !== (16'h8000 | 16'(n)) || mem_we !== 1'b1 || mem_wdata !== wr_data) bad++;
      last = mem_addr;
      n++;
      nxt();
    end
    chk("ff_count", 32'(n), 19200);
    chk("ff_contig", 32'(bad), 0);
    chk("ff_last", last, 16'hCAFF);
    chk("ff_rdy_low", wr_ready, 0);
    chk("ff_we_low", mem_we, 0);
    nxt();
    h_cnt = 10'd0; v_cnt = 10'd480;
    @(negedge pixel_clk);
    chk("ff_bank_pre", disp_bank, 0);
    chk("ff_swap_pre", swap_pulse, 0);
    nxt();
    h_cnt = 10'd1;
    @(negedge pixel_clk);
    chk("ff_bank", disp_bank, 1);
    chk("ff_swap", swap_pulse, 1);
    chk("ff_repeat", frame_repeat, 0);
    chk("ff_rdy", wr_ready, 1);
    chk("ff_next_addr", mem_addr, 16'h0000);
    nxt();
    h_cnt = 10'd2;
    @(negedge pixel_clk);
    chk("ff_swap_end", swap_pulse, 0);
    chk("ff_next_addr2", mem_addr, 16'h0001);

    // Reset in the middle of a write frame.
    #2 rst_n = 1'b0;
    #1 chk("mid_rst_bank", disp_bank, 0);
    nxt();
    rst_n = 1'b1; h_cnt = 10'd5; v_cnt = 10'd500;
    @(negedge pixel_clk);
    chk("mid_rst_addr", mem_addr, 16'h8000);
    wr_valid = 1'b0;
    nxt();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
